tpm_cmd_header_parser: RTL
==========================

Name: tpm_cmd_header_parser

Overview:
- Upstream feeder for management_module.
- Consumes the transport byte stream of one TPM command (big-endian) and extracts tag, commandSize, commandCode and the first parameter word.
- Validates framing, then drives tpm_cc/cmd_param and an active-low keyStart_n pulse into management_module.
- Holds the outputs stable until the downstream response path signals completion.

Parameters:
- MAX_CMD_SIZE, 4096, largest legal commandSize in bytes.
- PARAM_BYTES, 4, max parameter bytes captured into cmd_param (1..4).
- PULSE_CYCLES, 1, number of cycles keyStart_n is held low per dispatch (>=1).

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- byte_valid  in  1  byte_data valid this cycle.
- byte_data  in  8  command byte, MSB-first field order.
- byte_last  in  1  marks final byte of the transport frame; qualified by byte_valid.
- byte_ready  out  1  parser accepts byte this cycle; transfer = byte_valid & byte_ready.
- cmd_done  in  1  downstream finished current command; releases parser.
- keyStart_n  out  1  active-low dispatch strobe to management_module.
- cmd_tag  out  16  captured tag.
- cmd_size  out  32  captured commandSize.
- tpm_cc  out  32  captured commandCode.
- cmd_param  out  33  [32] = param present, [31:0] = captured parameter bytes, right-aligned.
- err_valid  out  1  one-cycle pulse: frame rejected.
- hdr_rc  out  32  response code of last frame (0 = success).
- parser_busy  out  1  high in every state except IDLE.

Behaviour:
- Reset values (async, reset_n low): state IDLE; byte_ready 1; keyStart_n 1; err_valid 0; parser_busy 0; all data outputs, hdr_rc and byte counter 0.
- A reset mid-frame discards the partial command with no pulse.
- States:
  - IDLE: first accepted byte -> TAG.
  - TAG: bytes 0-1.
  - SIZE: bytes 2-5.
  - CC: bytes 6-9.
  - PARAM: next min(PARAM_BYTES, size-10) bytes.
  - DRAIN: remaining bytes discarded.
  - DISPATCH.
  - WAIT_DONE.
  - REJECT.
- byte_ready = 1 in IDLE/TAG/SIZE/CC/PARAM/DRAIN; 0 in DISPATCH/WAIT_DONE/REJECT.
- Fields shift in MSB-first. A byte counter counts accepted bytes and saturates at MAX_CMD_SIZE+1 (no wrap).
- Parameter capture:
  - cmd_param[31:0] = collected bytes, right-aligned, with upper bytes zero. Example: 2 bytes 00 01 -> 33'h1_0000_0001.
  - If size==10, cmd_param = 0 (bit 32 clear).
- Errors are latched as sticky flags during the frame:
  - size_err: size<10 or size>MAX_CMD_SIZE; byte_last before count==size; or count reaches size without byte_last.
  - tag_err: tag not 16'h8001 or 16'h8002.
- After an error flag sets, the parser keeps accepting and discarding bytes until byte_last.
- Frame end (byte accepted with byte_last):
  - Error priority: size_err -> hdr_rc 32'h142; else tag_err -> 32'h01E; else success, hdr_rc 0.
  - Error: go to REJECT for 1 cycle (err_valid=1, keyStart_n stays 1), then IDLE.
  - Success: go to DISPATCH the next cycle.
- DISPATCH:
  - keyStart_n=0 for PULSE_CYCLES cycles, then WAIT_DONE.
  - First keyStart_n low cycle = 1 cycle after the byte_last acceptance.
- Output stability: tag/size/cc/param outputs are stable from the first DISPATCH cycle until leaving WAIT_DONE.
- cmd_done:
  - Sampled in DISPATCH and WAIT_DONE and latched.
  - The parser returns to IDLE on the cycle after both the pulse is complete and cmd_done has been seen.
  - cmd_done in any other state is ignored.
- Data outputs keep their last values in IDLE and are overwritten as the next frame's bytes are captured.
- byte_valid with byte_ready low: no transfer. The upstream source holds the byte.

Optional Feature:
- Macro: TPM_CC_RANGE_CHECK_EN.
- Defined: at frame end, a commandCode outside 32'h0000_011F..32'h0000_0193 (with no size/tag error) rejects with hdr_rc 32'h143 via REJECT.
- Undefined: no commandCode check; any code is dispatched.

Test Plan:
- Startup frame 80 01 00 00 00 0C 00 00 01 44 00 00 (byte_last on final byte) -> keyStart_n low 1 cycle, one cycle after last byte; tpm_cc=32'h144; cmd_param=33'h1_0000_0000; hdr_rc=0; byte_ready low until cmd_done, then IDLE.
- Bad tag 80 03 with a valid 12-byte frame -> err_valid pulse, hdr_rc=32'h01E, keyStart_n never low, byte_ready high next frame.
- byte_last on byte 8 of a size-12 frame -> hdr_rc=32'h142; a following good frame dispatches normally.
- Size 0x20 frame with 22 trailing bytes -> cmd_param holds only bytes 10-13, trailing bytes drained, single dispatch; cmd_done held off 5 cycles keeps outputs stable and byte_ready=0.
- reset_n low mid-PARAM -> all outputs reset values immediately, no keyStart_n pulse; next full frame parsed correctly.
- With TPM_CC_RANGE_CHECK_EN: code 32'h0000_0200 -> hdr_rc=32'h143, no dispatch; without the macro -> dispatched with tpm_cc=32'h200.

Source files
------------

// File: rtl/tpm_cmd_header_parser.sv
// TPM command header parser: frames a big-endian command byte stream,
// dispatches tag/size/code/param to management_module. Opt: TPM_CC_RANGE_CHECK_EN.
module tpm_cmd_header_parser #(
  parameter int MAX_CMD_SIZE = 4096,
  parameter int PARAM_BYTES  = 4,
  parameter int PULSE_CYCLES = 1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  input  logic        byte_last,
  output logic        byte_ready,
  input  logic        cmd_done,
  output logic        keyStart_n,
  output logic [15:0] cmd_tag,
  output logic [31:0] cmd_size,
  output logic [31:0] tpm_cc,
  output logic [32:0] cmd_param,
  output logic        err_valid,
  output logic [31:0] hdr_rc,
  output logic        parser_busy
);

  typedef enum logic [3:0] {
    IDLE,
    TAG,
    SIZE,
    CC,
    PARAM,
    DRAIN,
    DISPATCH,
    WAIT_DONE,
    REJECT
  } state_t;

  localparam logic [31:0] CNT_SAT = 32'(MAX_CMD_SIZE + 1);
  localparam logic [31:0] MAX_SZ  = 32'(MAX_CMD_SIZE);
  localparam logic [31:0] PB      = 32'(PARAM_BYTES);
  localparam logic [15:0] PL_LAST = 16'(PULSE_CYCLES - 1);
  localparam logic [31:0] RC_SIZE = 32'h0000_0142;
  localparam logic [31:0] RC_TAG  = 32'h0000_001E;
  localparam logic [31:0] RC_CC   = 32'h0000_0143;

  state_t      state;
  logic [31:0] cnt;
  logic        size_err;
  logic        tag_err;
  logic [15:0] pcnt;
  logic        done_seen;

  logic        xfer;
  logic        first;
  logic [31:0] idx;
  logic [31:0] idx_nxt;
  logic [15:0] tag_new;
  logic [31:0] size_new;
  logic [31:0] cc_new;
  logic [31:0] size_now;
  logic [31:0] cc_now;
  logic        serr_n;
  logic        terr_n;
  logic        cap;
  logic        cc_bad;
  state_t      rx_next;

  // Per-byte framing decode: field position, sticky error update, next rx state
  always_comb begin
    xfer     = byte_valid & byte_ready;
    first    = (state == IDLE);
    idx      = first ? 32'd0 : cnt;
    idx_nxt  = (idx >= CNT_SAT) ? CNT_SAT : idx + 32'd1;
    tag_new  = {cmd_tag[7:0], byte_data};
    size_new = {cmd_size[23:0], byte_data};
    cc_new   = {tpm_cc[23:0], byte_data};
    size_now = (idx == 32'd5) ? size_new : cmd_size;
    cc_now   = (idx == 32'd9) ? cc_new : tpm_cc;
    serr_n   = first ? 1'b0 : size_err;
    terr_n   = first ? 1'b0 : tag_err;
    cap      = 1'b0;
    cc_bad   = 1'b0;
    rx_next  = DRAIN;
    if (idx == 32'd1 && tag_new != 16'h8001 && tag_new != 16'h8002)
      terr_n = 1'b1;
    if (idx == 32'd5 && (size_new < 32'd10 || size_new > MAX_SZ))
      serr_n = 1'b1;
    if (byte_last) begin
      if (idx < 32'd5 || idx_nxt != size_now)
        serr_n = 1'b1;
    end else if (idx >= 32'd5 && idx_nxt == size_now) begin
      serr_n = 1'b1;
    end
    if (!serr_n && idx >= 32'd10 && idx < cmd_size
        && (idx - 32'd10) < PB)
      cap = 1'b1;
`ifdef TPM_CC_RANGE_CHECK_EN
    cc_bad = (cc_now < 32'h0000_011F) || (cc_now > 32'h0000_0193);
`else
    cc_bad = 1'b0;
`endif
    if (idx_nxt < 32'd2)
      rx_next = TAG;
    else if (idx_nxt < 32'd6)
      rx_next = SIZE;
    else if (idx_nxt < 32'd10)
      rx_next = CC;
    else if (!serr_n && idx_nxt < size_now
             && (idx_nxt - 32'd10) < PB)
      rx_next = PARAM;
    else
      rx_next = DRAIN;
  end

  // Main FSM: capture fields, judge the frame, pulse keyStart_n, await cmd_done
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      cnt         <= '0;
      size_err    <= 1'b0;
      tag_err     <= 1'b0;
      pcnt        <= '0;
      done_seen   <= 1'b0;
      byte_ready  <= 1'b1;
      keyStart_n  <= 1'b1;
      cmd_tag     <= '0;
      cmd_size    <= '0;
      tpm_cc      <= '0;
      cmd_param   <= '0;
      err_valid   <= 1'b0;
      hdr_rc      <= '0;
      parser_busy <= 1'b0;
    end else begin
      unique case (state)
        IDLE, TAG, SIZE, CC, PARAM, DRAIN: begin
          if (xfer) begin
            cnt      <= idx_nxt;
            size_err <= serr_n;
            tag_err  <= terr_n;
            if (first)
              cmd_param <= '0;
            if (idx < 32'd2)
              cmd_tag <= tag_new;
            else if (idx < 32'd6)
              cmd_size <= size_new;
            else if (idx < 32'd10)
              tpm_cc <= cc_new;
            else if (cap)
              cmd_param <= {1'b1, cmd_param[23:0], byte_data};
            parser_busy <= 1'b1;
            if (byte_last) begin
              byte_ready <= 1'b0;
              if (serr_n || terr_n || cc_bad) begin
                state     <= REJECT;
                err_valid <= 1'b1;
                hdr_rc    <= serr_n ? RC_SIZE :
                             terr_n ? RC_TAG : RC_CC;
              end else begin
                state      <= DISPATCH;
                hdr_rc     <= '0;
                keyStart_n <= 1'b0;
                pcnt       <= '0;
                done_seen  <= 1'b0;
              end
            end else begin
              state <= rx_next;
            end
          end
        end
        DISPATCH: begin
          if (cmd_done)
            done_seen <= 1'b1;
          if (pcnt == PL_LAST) begin
            keyStart_n <= 1'b1;
            state      <= WAIT_DONE;
          end else begin
            pcnt <= pcnt + 16'd1;
          end
        end
        WAIT_DONE: begin
          if (cmd_done)
            done_seen <= 1'b1;
          if (done_seen || cmd_done) begin
            state       <= IDLE;
            byte_ready  <= 1'b1;
            parser_busy <= 1'b0;
            done_seen   <= 1'b0;
          end
        end
        REJECT: begin
          err_valid   <= 1'b0;
          state       <= IDLE;
          byte_ready  <= 1'b1;
          parser_busy <= 1'b0;
        end
        default: begin
          state       <= IDLE;
          byte_ready  <= 1'b1;
          keyStart_n  <= 1'b1;
          err_valid   <= 1'b0;
          parser_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule
